// File: rtl/dsp_be_mlse_pkg.sv
// Shared types and constants for the MLSE configuration path.
// Latency: none (types and helper function only).
// Backpressure: none.
package dsp_be_mlse_pkg;

  localparam int MLSE_COEF_W = 8;

  // Writing this value is rejected: its negation is not representable in S5.2.
  localparam logic [MLSE_COEF_W-1:0] MLSE_CFG_ILLEGAL = 8'h80;

  typedef enum logic [1:0] {
    HM1    = 2'd0,
    HP1    = 2'd1,
    HX     = 2'd2,
    COMMIT = 2'd3
  } mlse_cfg_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    SETTLE   = 2'd2
  } mlse_cfg_state_e;

  typedef struct packed {
    logic [MLSE_COEF_W-1:0] hm1;
    logic [MLSE_COEF_W-1:0] hp1;
    logic [MLSE_COEF_W-1:0] hx;
  } mlse_coef_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int mlse_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_be_mlse_frame_cnt.sv
// Free-running frame position counter 0..FrameLen-1 with a boundary flag on the last cycle.
// Latency: count is registered; o_bnd decodes the registered count in the same cycle.
// Backpressure: none, runs continuously from reset.
module dsp_be_mlse_frame_cnt
  import dsp_be_mlse_pkg::*;
#(
  parameter int FrameLen = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  output logic [mlse_cnt_w(FrameLen)-1:0] o_count,
  output logic                            o_bnd
);

  localparam int CntW = mlse_cnt_w(FrameLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Next position: wrap to zero after the boundary cycle.
  always_comb begin
    count_d = count_q + CntW'(1);
    if (count_q == LastCnt) begin
      count_d = '0;
    end
  end

  // Position register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_bnd   = (count_q == LastCnt);

endmodule

// File: rtl/dsp_be_mlse_cfg_ctrl.sv
// Shadow/active coefficient sequencer: writes land in shadows, commits apply atomically on a frame boundary.
// Latency: write-to-shadow 1 cycle; commit applies on the first boundary edge after acceptance, then qual low SettleCycles.
// Backpressure: o_req_ready is low while a commit is pending or settling (and during the post-reset settle window).
module dsp_be_mlse_cfg_ctrl
  import dsp_be_mlse_pkg::*;
#(
  parameter int FrameLen     = 64,
  parameter int SettleCycles = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [1:0]             i_req_sel,
  input  logic [MLSE_COEF_W-1:0] i_req_data,
  input  logic                   i_err_clr,
  output logic [MLSE_COEF_W-1:0] o_cfg_eq_hm1,
  output logic [MLSE_COEF_W-1:0] o_cfg_eq_hp1,
  output logic [MLSE_COEF_W-1:0] o_cfg_eq_hx,
  output logic                   o_dat_qual,
  output logic                   o_busy,
  output logic                   o_err,
  output logic [3:0]             o_cfg_epoch,
  output logic                   o_frame_bnd
);

  localparam int CntW = mlse_cnt_w(FrameLen);
  localparam int SetW = mlse_cnt_w(SettleCycles);
  localparam logic [SetW-1:0] SettleInit = SetW'(SettleCycles - 1);

  mlse_cfg_state_e state_q, state_d;
  logic [SetW-1:0] settle_q, settle_d;
  mlse_coef_t      shadow_q, shadow_d;
  mlse_coef_t      active_q, active_d;
  logic [3:0]      epoch_q, epoch_d;
  logic            qual_q, qual_d;
  logic            err_q, err_d;

  logic            frame_bnd;
  logic [CntW-1:0] frame_cnt_unused;
  logic            req_ready;
  logic            req_accept;
  logic            err_set;
  mlse_cfg_sel_e   req_sel;

  dsp_be_mlse_frame_cnt #(
    .FrameLen(FrameLen)
  ) u_frame_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_count(frame_cnt_unused),
    .o_bnd  (frame_bnd)
  );

  assign req_sel    = mlse_cfg_sel_e'(i_req_sel);
  assign req_ready  = (state_q == IDLE);
  assign req_accept = i_req_valid & req_ready;

  // Request handling, commit sequencing and sticky error; every target defaulted to hold.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    active_d = active_q;
    epoch_d  = epoch_q;
    qual_d   = qual_q;
    err_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_accept) begin
          if (req_sel == COMMIT) begin
            state_d = WAIT_BND;
          end else if (i_req_data == MLSE_CFG_ILLEGAL) begin
            err_set = 1'b1;
          end else begin
            case (req_sel)
              HM1:     shadow_d.hm1 = i_req_data;
              HP1:     shadow_d.hp1 = i_req_data;
              HX:      shadow_d.hx  = i_req_data;
              default: shadow_d     = shadow_q;
            endcase
          end
        end
      end
      WAIT_BND: begin
        // All three coefficients swap on the same edge so the ALUs never see a mix.
        if (frame_bnd) begin
          active_d = shadow_q;
          epoch_d  = epoch_q + 4'd1;
          qual_d   = 1'b0;
          settle_d = SettleInit;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          qual_d  = 1'b1;
          state_d = IDLE;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as a clear must win.
    err_d = err_set | (err_q & ~i_err_clr);
  end

  // State and datapath registers; reset enters SETTLE so qualification waits out the window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SETTLE;
      settle_q <= SettleInit;
      shadow_q <= '0;
      active_q <= '0;
      epoch_q  <= '0;
      qual_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      epoch_q  <= epoch_d;
      qual_q   <= qual_d;
      err_q    <= err_d;
    end
  end

  assign o_req_ready  = req_ready;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_bnd  = frame_bnd;
  assign o_cfg_eq_hm1 = active_q.hm1;
  assign o_cfg_eq_hp1 = active_q.hp1;
  assign o_cfg_eq_hx  = active_q.hx;
  assign o_cfg_epoch  = epoch_q;
  assign o_dat_qual   = qual_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_dsp_be_mlse_cfg_ctrl.sv
// Directed bench for the MLSE configuration sequencer (FrameLen=8, SettleCycles=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Frame position is tracked by counting falling edges since reset release.
module tb_dsp_be_mlse_cfg_ctrl;

  localparam int FL = 8;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] data = 8'h00;
  logic       err_clr = 1'b0;

  logic       req_ready;
  logic [7:0] hm1, hp1, hx;
  logic       dat_qual, busy, err, frame_bnd;
  logic [3:0] epoch;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  dsp_be_mlse_cfg_ctrl #(
    .FrameLen    (FL),
    .SettleCycles(SC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .o_req_ready (req_ready),
    .i_req_sel   (sel),
    .i_req_data  (data),
    .i_err_clr   (err_clr),
    .o_cfg_eq_hm1(hm1),
    .o_cfg_eq_hp1(hp1),
    .o_cfg_eq_hx (hx),
    .o_dat_qual  (dat_qual),
    .o_busy      (busy),
    .o_err       (err),
    .o_cfg_epoch (epoch),
    .o_frame_bnd (frame_bnd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic c);
    valid   = v;
    sel     = s;
    data    = d;
    err_clr = c;
  endtask

  function automatic logic [31:0] coefs();
    return {8'h00, hm1, hp1, hx};
  endfunction

  function automatic logic bnd_model();
    return (cyc % FL) == (FL - 1);
  endfunction

  initial begin
    // Reset held over a few edges, then released; N0 is the first sample after release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    chk("rst_coefs", coefs(), 32'h0);
    chk("rst_epoch", epoch, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_bnd", frame_bnd, 1'b0);
    chk("rst_qual_low", dat_qual, 1'b0);
    chk("rst_ready_low", req_ready, 1'b0);
    for (int k = 1; k < SC; k++) begin
      tick();
      chk("rst_qual_low", dat_qual, 1'b0);
      chk("rst_ready_low", req_ready, 1'b0);
    end
    tick();  // N4
    chk("rst_qual_rise", dat_qual, 1'b1);
    chk("rst_ready_rise", req_ready, 1'b1);
    chk("rst_idle", busy, 1'b0);

    // Shadow writes, then commit at frame count 2.
    drive(1'b1, 2'd0, 8'h0C, 1'b0); tick();  // N5
    drive(1'b1, 2'd1, 8'h10, 1'b0); tick();  // N6
    drive(1'b1, 2'd2, 8'hF8, 1'b0); tick();  // N7
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("shadow_hidden", coefs(), 32'h0);
    chk("bnd_at_7", frame_bnd, bnd_model());
    repeat (3) tick();  // N10, count 2
    chk("bnd_at_2", frame_bnd, bnd_model());
    drive(1'b1, 2'd3, 8'h00, 1'b0); tick();  // N11
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("wait_ready_low", req_ready, 1'b0);
    chk("wait_busy", busy, 1'b1);
    repeat (4) tick();  // N15, boundary cycle
    chk("pre_apply_bnd", frame_bnd, 1'b1);
    chk("pre_apply_coefs", coefs(), 32'h0);
    chk("pre_apply_ready", req_ready, 1'b0);
    tick();  // N16
    chk("apply_coefs", coefs(), 32'h000C10F8);
    chk("apply_epoch", epoch, 4'd1);
    chk("apply_qual_low", dat_qual, 1'b0);
    chk("apply_ready_low", req_ready, 1'b0);
    for (int k = 1; k < SC; k++) begin
      tick();
      chk("settle_qual_low", dat_qual, 1'b0);
      chk("settle_ready_low", req_ready, 1'b0);
    end
    tick();  // N20
    chk("settle_qual_rise", dat_qual, 1'b1);
    chk("settle_ready_rise", req_ready, 1'b1);

    // Illegal hx write is rejected; following commit applies the old hx.
    drive(1'b1, 2'd2, 8'h80, 1'b0); tick();  // N21
    chk("illegal_err", err, 1'b1);
    drive(1'b1, 2'd3, 8'h00, 1'b0); tick();  // N22
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();  // N23
    chk("bnd_at_23", frame_bnd, bnd_model());
    tick();  // N24
    chk("old_hx_applied", coefs(), 32'h000C10F8);
    chk("epoch_2", epoch, 4'd2);
    chk("err_sticky", err, 1'b1);
    repeat (4) tick();  // N28
    chk("qual_back_28", dat_qual, 1'b1);
    drive(1'b1, 2'd0, 8'h80, 1'b1); tick();  // N29: set and clear together
    chk("set_beats_clr", err, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b1); tick();  // N30
    chk("err_cleared", err, 1'b0);

    // Commit accepted on the boundary cycle waits a full frame.
    drive(1'b1, 2'd1, 8'h22, 1'b0); tick();  // N31
    chk("bnd_commit_cycle", frame_bnd, 1'b1);
    chk("bnd_commit_ready", req_ready, 1'b1);
    drive(1'b1, 2'd3, 8'h00, 1'b0); tick();  // N32
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("bnd_commit_busy", busy, 1'b1);
    chk("bnd_commit_not_now", coefs(), 32'h000C10F8);
    repeat (7) tick();  // N39
    chk("bnd_commit_still_old", coefs(), 32'h000C10F8);
    tick();  // N40
    chk("bnd_commit_applied", coefs(), 32'h000C22F8);
    chk("epoch_3", epoch, 4'd3);
    chk("bnd_commit_qual_low", dat_qual, 1'b0);
    repeat (4) tick();  // N44
    chk("qual_back_44", dat_qual, 1'b1);

    // Reset in the middle of a pending commit discards the shadow.
    drive(1'b1, 2'd0, 8'h20, 1'b0); tick();  // N45
    drive(1'b1, 2'd3, 8'h00, 1'b0); tick();  // N46
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("midcommit_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    chk("rst2_coefs", coefs(), 32'h0);
    chk("rst2_epoch", epoch, 4'd0);
    chk("rst2_qual", dat_qual, 1'b0);
    chk("rst2_busy", busy, 1'b1);
    chk("rst2_bnd", frame_bnd, 1'b0);
    repeat (SC) tick();  // N4
    chk("rst2_ready", req_ready, 1'b1);
    drive(1'b1, 2'd3, 8'h00, 1'b0); tick();  // N5
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    repeat (3) tick();  // N8
    chk("rst2_commit_zero", coefs(), 32'h0);
    chk("rst2_commit_epoch", epoch, 4'd1);
    chk("rst2_commit_qual", dat_qual, 1'b0);

    // Remaining 15 commits take the epoch through 15 and back to 0.
    for (int i = 0; i < 15; i++) begin
      int n;
      n = 0;
      while (!req_ready && n < 40) begin
        tick();
        n++;
      end
      chk("loop_ready", req_ready, 1'b1);
      drive(1'b1, 2'd3, 8'h00, 1'b0); tick();
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      chk("loop_busy", busy, 1'b1);
      n = 0;
      while (busy && n < 40) begin
        tick();
        n++;
      end
      chk("loop_done", busy, 1'b0);
      chk("loop_epoch", epoch, 32'((2 + i) % 16));
    end
    chk("epoch_wrap", epoch, 4'd0);
    chk("loop_qual", dat_qual, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
